// File: rtl/orb_serializer.sv
// Orbit-word serializer: reads the packer's buffer RAM sequentially and shifts each word out
// MSB-first at CLK_DIV clocks per bit. Optional feature macro: ORB_PARITY_EN (odd parity in bit 0).
module orb_serializer #(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned CLK_DIV = 8,
  parameter int unsigned WORD_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WORD_W-1:0] rdData,
  output logic [ADDR_W-1:0] rdAddr,
  output logic              rdEn,
  output logic              orbBit,
  output logic              bitStb,
  output logic              wordStb,
  output logic              frameStb,
  output logic              req,
  output logic              busy
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IdxW = $clog2(WORD_W);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [IdxW-1:0] BitLast = IdxW'(WORD_W - 1);

  typedef enum logic [1:0] {StIdle, StPrefetch, StRun} state_e;

  state_e              state_q, state_d;
  logic                en_meta_q, en_s_q;
  logic [ADDR_W-1:0]   cur_addr_q, rd_addr_q;
  logic                rd_en_q;
  logic [WORD_W-1:0]   hold_q, shift_q;
  logic [IdxW-1:0]     bit_idx_q;
  logic [DivW-1:0]     cnt_div_q;
  logic [1:0]          pf_q;
  logic                word_end;

  // The marker overwrites the MSB, so the RAM word's own MSB is never transmitted.
  logic unused_rd_msb;
  assign unused_rd_msb = rdData[WORD_W-1];

  function automatic logic [WORD_W-1:0] mark(input logic [WORD_W-1:0] w,
                                             input logic [ADDR_W-1:0] a);
    logic [WORD_W-1:0] m;
    m = {(a == '0), w[WORD_W-2:0]};
`ifdef ORB_PARITY_EN
    m[0] = ~^m[WORD_W-1:1];
`endif
    return m;
  endfunction

  assign word_end = (cnt_div_q == DivLast) && (bit_idx_q == BitLast);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_meta_q <= 1'b0;
      en_s_q    <= 1'b0;
    end else begin
      en_meta_q <= en;
      en_s_q    <= en_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (en_s_q) state_d = StPrefetch;
      StPrefetch: if (pf_q == 2'd2) state_d = StRun;
      StRun:      if (word_end && !en_s_q) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_addr_q <= '0;
      rd_addr_q  <= '0;
      rd_en_q    <= 1'b0;
      hold_q     <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      cnt_div_q  <= '0;
      pf_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cur_addr_q <= '0;
          shift_q    <= '0;
          bit_idx_q  <= '0;
          cnt_div_q  <= '0;
          pf_q       <= '0;
          if (en_s_q) begin
            rd_addr_q <= '0;
            rd_en_q   <= 1'b1;
          end
        end
        StPrefetch: begin
          pf_q <= pf_q + 2'd1;
          if (pf_q == 2'd0) rd_en_q <= 1'b0;
          if (pf_q == 2'd1) hold_q <= rdData;
          if (pf_q == 2'd2) begin
            shift_q   <= mark(hold_q, '0);
            bit_idx_q <= '0;
            cnt_div_q <= '0;
            pf_q      <= '0;
            rd_addr_q <= ADDR_W'(1);
            rd_en_q   <= 1'b1;
          end
        end
        StRun: begin
          cnt_div_q <= (cnt_div_q == DivLast) ? '0 : cnt_div_q + DivW'(1);
          // Next word's read is presented on this word's first clk; data lands one clk later.
          if (cnt_div_q == '0 && bit_idx_q == '0) rd_en_q <= 1'b0;
          if (cnt_div_q == DivW'(1) && bit_idx_q == '0) hold_q <= rdData;
          if (cnt_div_q == DivLast) begin
            if (bit_idx_q != BitLast) begin
              shift_q   <= {shift_q[WORD_W-2:0], 1'b0};
              bit_idx_q <= bit_idx_q + IdxW'(1);
            end else if (en_s_q) begin
              cur_addr_q <= cur_addr_q + ADDR_W'(1);
              shift_q    <= mark(hold_q, cur_addr_q + ADDR_W'(1));
              bit_idx_q  <= '0;
              rd_addr_q  <= cur_addr_q + ADDR_W'(2);
              rd_en_q    <= 1'b1;
            end else begin
              cur_addr_q <= '0;
              shift_q    <= '0;
              bit_idx_q  <= '0;
              cnt_div_q  <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rdAddr = rd_addr_q;
  assign rdEn   = rd_en_q;

  always_comb begin
    orbBit   = 1'b0;
    bitStb   = 1'b0;
    wordStb  = 1'b0;
    frameStb = 1'b0;
    req      = 1'b0;
    busy     = (state_q != StIdle);
    if (state_q == StRun) begin
      orbBit   = shift_q[WORD_W-1];
      bitStb   = (cnt_div_q == '0);
      wordStb  = bitStb && (bit_idx_q == '0);
      frameStb = wordStb && (cur_addr_q == '0);
      req      = wordStb && (cur_addr_q[4:0] == 5'd0);
    end
  end

endmodule

// File: tb/tb_orb_serializer.sv
// Directed bench for orb_serializer with a 64-word buffer (ADDR_W=6) and CLK_DIV=4.
module tb_orb_serializer;
  localparam int unsigned AW  = 6;
  localparam int unsigned DIV = 4;

`ifdef ORB_PARITY_EN
  localparam logic [11:0] W0 = 12'hBA9;
  localparam logic [11:0] W1 = 12'h7FF;
  localparam logic [11:0] W5 = 12'h0F1;
`else
  localparam logic [11:0] W0 = 12'hBA8;
  localparam logic [11:0] W1 = 12'h7FF;
  localparam logic [11:0] W5 = 12'h0F0;
`endif

  logic          clk = 1'b0;
  logic          rst, en;
  logic [11:0]   rdData = '0;
  logic [AW-1:0] rdAddr;
  logic          rdEn, orbBit, bitStb, wordStb, frameStb, req, busy;
  logic [11:0]   mem [64];

  int vectors = 0;
  int miscompares = 0;
  int req_seen = 0;

  orb_serializer #(.ADDR_W(AW), .CLK_DIV(DIV), .WORD_W(12)) dut (
    .clk(clk), .rst(rst), .en(en), .rdData(rdData), .rdAddr(rdAddr), .rdEn(rdEn),
    .orbBit(orbBit), .bitStb(bitStb), .wordStb(wordStb), .frameStb(frameStb), .req(req),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rdEn) rdData <= mem[rdAddr];

  always @(negedge clk) if (req) req_seen <= req_seen + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] exp_word(input logic [11:0] w, input int a);
    logic [11:0] m;
    m = {(a == 0) ? 1'b1 : 1'b0, w[10:0]};
`ifdef ORB_PARITY_EN
    m[0] = ~^m[11:1];
`endif
    return m;
  endfunction

  // Called on a word's first clk; returns on the first clk after the word.
  task automatic rx_word(input int drop_bit, output logic [11:0] w);
    w = '0;
    for (int i = 0; i < 12; i++) begin
      check("bit_stb", 32'(bitStb), 32'd1);
      w = {w[10:0], orbBit};
      if (i == drop_bit) en = 1'b0;
      repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic wait_word(output int n, output logic got_rd, output logic [AW-1:0] first_addr);
    n = 0;
    got_rd = 1'b0;
    first_addr = '1;
    while (!wordStb && n < 20) begin
      @(negedge clk);
      n++;
      if (rdEn && !got_rd) begin
        got_rd = 1'b1;
        first_addr = rdAddr;
      end
    end
  endtask

  initial begin
    logic [11:0]   w;
    logic          got_rd;
    logic [AW-1:0] a0;
    int            n, base;

    for (int i = 0; i < 64; i++) mem[i] = 12'(i * 667 + 21);
    mem[0] = 12'h3A8;
    mem[1] = 12'hFFF;
    mem[5] = 12'h0F0;
    rst = 1'b0;
    en  = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outs", 32'({orbBit, bitStb, wordStb, frameStb, req, busy, rdEn}), 32'd0);
    check("reset_addr", 32'(rdAddr), 32'd0);

    // Two sync clocks, then 1 IDLE + 3 PREFETCH before the first bit.
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k < 6) check("latency_no_bit", 32'(bitStb), 32'd0);
      if (k == 3) check("prefetch_rd", 32'({busy, rdEn, rdAddr}), 32'({2'b11, 6'd0}));
    end
    check("w0_strobes", 32'({bitStb, wordStb, frameStb, req}), 32'hF);
    check("w0_rd", 32'({rdEn, rdAddr}), 32'({1'b1, 6'd1}));
    rx_word(-1, w);
    check("w0_data", 32'(w), 32'(W0));

    check("w1_strobes", 32'({wordStb, frameStb, req}), 32'b100);
    check("w1_rd", 32'({rdEn, rdAddr}), 32'({1'b1, 6'd2}));
    rx_word(-1, w);
    check("w1_data", 32'(w), 32'(W1));

    base = req_seen;
    for (int k = 2; k <= 65; k++) begin
      int a;
      a = k % 64;
      check("word_stb", 32'(wordStb), 32'd1);
      check("frame_stb", 32'(frameStb), 32'(a == 0));
      check("req", 32'(req), 32'(a % 32 == 0));
      rx_word(-1, w);
      check("word_data", 32'(w), 32'(exp_word(mem[a], a)));
`ifdef ORB_PARITY_EN
      check("odd_parity", 32'(^w), 32'd1);
`endif
      if (a == 5) check("w5_data", 32'(w), 32'(W5));
      if (a == 0) check("wrap_w0_data", 32'(w), 32'(W0));
    end
    check("req_count", 32'(req_seen - base), 32'd2);

    // Reset mid-word 2 at bit 3.
    repeat (3 * DIV) @(negedge clk);
    check("pre_rst_busy", 32'({busy, bitStb}), 32'b11);
    rst = 1'b0;
    #1;
    check("mid_rst_outs", 32'({orbBit, bitStb, wordStb, frameStb, req, busy, rdEn}), 32'd0);
    check("mid_rst_addr", 32'(rdAddr), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    wait_word(n, got_rd, a0);
    check("rst_restart_lat", 32'(n), 32'd6);
    check("rst_restart_frame", 32'(frameStb), 32'd1);
    rx_word(-1, w);
    check("rst_w0_data", 32'(w), 32'(W0));
    for (int a = 1; a <= 6; a++) begin
      rx_word(-1, w);
      check("pre_drop_data", 32'(w), 32'(exp_word(mem[a], a)));
    end

    // Drop en at bit 5 of word 7; the word must still complete.
    rx_word(5, w);
    check("w7_full_data", 32'(w), 32'(exp_word(mem[7], 7)));
    check("drop_idle", 32'({busy, orbBit, bitStb}), 32'd0);
    repeat (10) @(negedge clk);
    check("still_idle", 32'({busy, rdEn, orbBit}), 32'd0);

    en = 1'b1;
    wait_word(n, got_rd, a0);
    check("reen_lat", 32'(n), 32'd6);
    check("reen_first_rd", 32'({got_rd, a0}), 32'({1'b1, 6'd0}));
    check("reen_frame", 32'(frameStb), 32'd1);
    rx_word(-1, w);
    check("reen_w0_data", 32'(w), 32'(W0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/orb_serializer.md
Name: orb_serializer

Overview:
- Downstream stage of the orbit packer; consumes the 12-bit orbit-word buffer RAM (2^ADDR_W words) that the packer fills.
- Reads the buffer sequentially through a synchronous read port and shifts each word out MSB-first as a serial telemetry bit stream at a divided bit rate.
- Forces a frame marker into word 0 of every frame.
- Emits a one-clock `req` pulse at every 32-word packet boundary, which feeds the packer's `req` input.

Parameters:
- ADDR_W, 11, buffer address width; frame length = 2^ADDR_W words.
- CLK_DIV, 8, clk cycles per serial bit; must be >= 4.
- WORD_W, 12, bits per orbit word (fixed; not intended to be overridden).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  transmit enable, asynchronous level; 2-flop synchronised internally
- rdData  in  12  buffer RAM read data, valid 1 clk after rdEn
- rdAddr  out  ADDR_W  buffer RAM read address
- rdEn  out  1  buffer RAM read enable, one-clk pulse
- orbBit  out  1  serial data, MSB first
- bitStb  out  1  one-clk pulse on the first clk of every bit
- wordStb  out  1  one-clk pulse on the first clk of every word
- frameStb  out  1  one-clk pulse on the first clk of word 0
- req  out  1  one-clk pulse on the first clk of every word whose address[4:0]==0
- busy  out  1  high in PREFETCH and RUN

Behaviour:
- Reset: all outputs 0; internal regs 0; state IDLE.
  - Reset mid-frame aborts immediately.
  - After release, transmission restarts at address 0.
- en is synchronised by a 2-flop stage. Only the synchronised value (enS) is used.
- States: IDLE, PREFETCH, RUN.
- IDLE:
  - orbBit=0, rdEn=0, curAddr=0.
  - On enS=1: rdAddr<=0, rdEn<=1, go to PREFETCH.
- PREFETCH (3 clk):
  - clk1: rdEn<=0.
  - clk2: hold<=rdData.
  - clk3: shift<=mark(hold, addr 0); bitIdx<=0; cntDiv<=0; issue read of address 1; go to RUN.
- RUN:
  - cntDiv counts 0..CLK_DIV-1 and wraps. Bit period = CLK_DIV clk exactly.
  - orbBit = shift[11] throughout the bit.
  - When cntDiv==0: bitStb=1.
  - When cntDiv==0 and bitIdx==0: wordStb=1; frameStb=1 if curAddr==0; req=1 if curAddr[4:0]==0.
  - When cntDiv==0 and bitIdx==0, also: rdAddr<=curAddr+1 (mod 2^ADDR_W) and rdEn<=1 for one clk. Capture hold<=rdData 2 clk later; CLK_DIV>=4 guarantees capture before the word ends.
  - At cntDiv==CLK_DIV-1 with bitIdx<11: shift<<=1 (LSB fill 0); bitIdx++.
  - At cntDiv==CLK_DIV-1 with bitIdx==11 (word end):
    - curAddr<=curAddr+1, wrapping 2^ADDR_W-1 -> 0 (a new frame starts with no gap).
    - shift<=mark(hold, next address); bitIdx<=0.
    - If enS==0 at this clk: instead go to IDLE, orbBit<=0.
  - Words are back-to-back: no idle bits between words or between frames.
- mark(w, a):
  - bit11 = (a==0) ? 1 : 0, i.e. frame marker;
  - bits 10:0 = w[10:0].
- en low mid-word: the current word completes in full, then the block goes to IDLE. A later enS rise restarts at address 0 via PREFETCH.
- en re-asserted before the word end: no effect; transmission continues uninterrupted.
- Latency: enS rise -> first bitStb = 4 clk (1 IDLE + 3 PREFETCH).
- rdData is only sampled 2 clk after an rdEn pulse. Writes by the packer to other addresses are never interfered with.

Optional Feature:
- Macro: ORB_PARITY_EN.
- Defined: bit0 of every transmitted word is replaced by odd parity over transmitted bits 11:1, marker included; the XOR of all 12 bits = 1. Computed when shift is loaded, with no added latency.
- Undefined: bit0 is transmitted unchanged from rdData[0].

Test Plan:
- Reset with en=1, then release with RAM[0]=12'h3A8, CLK_DIV=4 -> first bitStb 4 clk after enS; orbBit sequence 1,0,1,1,1,0,1,0,1,0,0,0 (h BA8, marker set); frameStb, wordStb and req all high on that first clk.
- RAM[1]=12'hFFF -> word 1 is transmitted as h7FF (marker cleared); rdEn pulses with rdAddr=2 on word 1's first clk; no req pulse.
- ADDR_W=6 sim: run past address 63 -> word 0 follows word 63 with no gap; frameStb asserts again; req pulses at addresses 0 and 32 only.
- Drop en at bit 5 of word 7 -> word 7 completes all 12 bits; busy falls the clk after the word end; orbBit=0; on re-enable the first word read is address 0.
- Assert rst low at bit 3 of word 2 -> all outputs 0 immediately; after release with en=1 the stream restarts at word 0.
- ORB_PARITY_EN defined, RAM[5]=12'h0F0 -> transmitted word is h0F1, and every transmitted word has odd overall parity.
